// File: rtl/store_access_unit_pkg.sv
// Shared definitions for the store path: size encodings, FSM state codes and
// the load-side DATA_* lane constants.
package store_access_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_NONE = 2'b00,
    SIZE_BYTE = 2'b01,
    SIZE_HALF = 2'b10,
    SIZE_WORD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_ERR   = 2'b11
  } state_t;

  // Lane widths and masks shared with the load-side extractor.
  localparam int          DATA_BYTE_BITS = 8;
  localparam int          DATA_HALF_BITS = 16;
  localparam int          DATA_WORD_BITS = 32;
  localparam logic [31:0] DATA_BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] DATA_HALF_MASK = 32'h0000_FFFF;
  localparam logic [31:0] DATA_WORD_MASK = 32'hFFFF_FFFF;

endpackage

// File: rtl/store_merge.sv
// Little-endian lane merge: overlays the store data onto the old memory word
// according to size and byte offset.
module store_merge
  import store_access_unit_pkg::*;
#(
  parameter int NB_BITS = 32
) (
  input  logic [NB_BITS-1:0] i_old,
  input  logic [NB_BITS-1:0] i_data,
  input  size_t              i_size,
  input  logic [1:0]         i_lane,
  output logic [NB_BITS-1:0] o_word
);

  logic [4:0] byte_lsb;
  logic [4:0] half_lsb;

  assign byte_lsb = {i_lane, 3'b000};
  assign half_lsb = {i_lane[1], 4'b0000};

  always_comb begin
    o_word = i_old;
    case (i_size)
      SIZE_BYTE: o_word[byte_lsb +: DATA_BYTE_BITS] = i_data[DATA_BYTE_BITS-1:0];
      SIZE_HALF: o_word[half_lsb +: DATA_HALF_BITS] = i_data[DATA_HALF_BITS-1:0];
      SIZE_WORD: o_word = i_data;
      default:   o_word = i_old;
    endcase
  end

endmodule

// File: rtl/store_access_unit.sv
// Store access unit: accepts MEM-stage stores, performs read-modify-write for
// sub-word stores and rejects misaligned HALF/WORD accesses.
module store_access_unit
  import store_access_unit_pkg::*;
#(
  parameter int NB_BITS = 32,
  parameter int NB_ADDR = 10
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_BITS-1:0] i_addr,
  input  logic [NB_BITS-1:0] i_data,
  input  logic [1:0]         i_size,
  output logic               o_ready,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic               o_mem_re,
  output logic               o_mem_we,
  output logic [NB_BITS-1:0] o_mem_wdata,
  input  logic [NB_BITS-1:0] i_mem_rdata,
  output logic               o_done,
  output logic               o_misaligned
);

  state_t             state;
  state_t             state_nxt;
  size_t              req_size;
  logic               accept;
  logic [NB_BITS-1:0] merged;

  logic [NB_ADDR-1:0] waddr_p0;
  logic [1:0]         lane_p0;
  logic [NB_BITS-1:0] data_p0;
  size_t              size_p0;

  // Address bits above the memory size wrap away by design.
  logic               unused_addr_hi;
  assign unused_addr_hi = ^i_addr[NB_BITS-1:NB_ADDR+2];

  function automatic logic is_misaligned(input size_t size, input logic [1:0] lane);
    return ((size == SIZE_HALF) && lane[0]) ||
           ((size == SIZE_WORD) && (lane != 2'b00));
  endfunction

  assign req_size = size_t'(i_size);
  assign accept   = i_valid && (state == ST_IDLE) && (req_size != SIZE_NONE);

  // Acceptance stage: latch the request and advance the FSM.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= ST_IDLE;
      waddr_p0 <= '0;
      lane_p0  <= '0;
      data_p0  <= '0;
      size_p0  <= SIZE_NONE;
    end else begin
      state <= state_nxt;
      if (accept) begin
        waddr_p0 <= i_addr[NB_ADDR+1:2];
        lane_p0  <= i_addr[1:0];
        data_p0  <= i_data;
        size_p0  <= req_size;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_misaligned(req_size, i_addr[1:0])) state_nxt = ST_ERR;
          else if (req_size == SIZE_WORD)           state_nxt = ST_WRITE;
          else                                      state_nxt = ST_READ;
        end
      end
      ST_READ:  state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_IDLE;
      ST_ERR:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The read word arrives during WRITE, one cycle after the READ strobe.
  store_merge #(
    .NB_BITS(NB_BITS)
  ) u_merge (
    .i_old (i_mem_rdata),
    .i_data(data_p0),
    .i_size(size_p0),
    .i_lane(lane_p0),
    .o_word(merged)
  );

  always_comb begin
    o_ready      = (state == ST_IDLE);
    o_mem_re     = (state == ST_READ);
    o_mem_we     = (state == ST_WRITE);
    o_done       = (state == ST_WRITE);
    o_misaligned = (state == ST_ERR);
    o_mem_addr   = (state == ST_IDLE) ? '0 : waddr_p0;
    o_mem_wdata  = (state == ST_WRITE) ? merged : '0;
  end

endmodule

// File: tb/tb_store_access_unit.sv
// Directed bench for store_access_unit with a one-cycle-latency memory model.
module tb_store_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic [1:0]  i_size;
  logic        o_ready;
  logic [9:0]  o_mem_addr;
  logic        o_mem_re;
  logic        o_mem_we;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata = '0;
  logic        o_done;
  logic        o_misaligned;
  logic [31:0] mem_word = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) i_mem_rdata <= o_mem_re ? mem_word : 32'h0;

  store_access_unit #(.NB_BITS(32), .NB_ADDR(10)) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_valid     (i_valid),
    .i_addr      (i_addr),
    .i_data      (i_data),
    .i_size      (i_size),
    .o_ready     (o_ready),
    .o_mem_addr  (o_mem_addr),
    .o_mem_re    (o_mem_re),
    .o_mem_we    (o_mem_we),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata),
    .o_done      (o_done),
    .o_misaligned(o_misaligned)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    i_valid = 1'b1;
    i_size  = size;
    i_addr  = addr;
    i_data  = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_valid = 1'b0; i_size = 2'b00; i_addr = '0; i_data = '0;
    tick(); tick();
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    checks++; if ({o_mem_re, o_mem_we, o_done, o_misaligned} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes got=%b exp=0000", {o_mem_re, o_mem_we, o_done, o_misaligned}); end
    checks++; if (o_mem_addr !== 10'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", o_mem_addr); end
    checks++; if (o_mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", o_mem_wdata); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_word();
    logic [31:0] addrs [2] = '{32'h0000_0010, 32'hFFFF_F010};
    logic [31:0] datas [2] = '{32'hDEAD_BEEF, 32'h0BAD_F00D};
    for (int i = 0; i < 2; i++) begin
      request(2'b11, addrs[i], datas[i]);
      tick();
      i_valid = 1'b0;
      checks++; if (o_mem_we !== 1'b1 || o_mem_re !== 1'b0) begin
        failures++; $display("FAIL word_strobe[%0d] we=%b re=%b exp we=1 re=0", i, o_mem_we, o_mem_re); end
      checks++; if (o_mem_addr !== 10'd4) begin failures++; $display("FAIL word_addr[%0d] got=%0d exp=4", i, o_mem_addr); end
      checks++; if (o_mem_wdata !== datas[i]) begin failures++; $display("FAIL word_wdata[%0d] got=%h exp=%h", i, o_mem_wdata, datas[i]); end
      checks++; if (o_done !== 1'b1 || o_ready !== 1'b0) begin
        failures++; $display("FAIL word_done[%0d] done=%b ready=%b exp done=1 ready=0", i, o_done, o_ready); end
      tick();
      checks++; if (o_ready !== 1'b1 || o_mem_we !== 1'b0 || o_mem_addr !== 10'd0) begin
        failures++; $display("FAIL word_idle[%0d] ready=%b we=%b addr=%0d exp 1/0/0", i, o_ready, o_mem_we, o_mem_addr); end
    end
  endtask

  task automatic test_byte();
    mem_word = 32'h1122_3344;
    request(2'b01, 32'h0000_000D, 32'h0000_00AB);
    tick();
    i_valid = 1'b0;
    checks++; if (o_mem_re !== 1'b1 || o_mem_we !== 1'b0 || o_mem_addr !== 10'd3) begin
      failures++; $display("FAIL byte_read re=%b we=%b addr=%0d exp 1/0/3", o_mem_re, o_mem_we, o_mem_addr); end
    tick();
    checks++; if (o_mem_we !== 1'b1 || o_mem_re !== 1'b0 || o_done !== 1'b1) begin
      failures++; $display("FAIL byte_write we=%b re=%b done=%b exp 1/0/1", o_mem_we, o_mem_re, o_done); end
    checks++; if (o_mem_wdata !== 32'h1122_AB44) begin failures++; $display("FAIL byte_wdata got=%h exp=1122ab44", o_mem_wdata); end
    tick();
    checks++; if (o_ready !== 1'b1 || o_done !== 1'b0) begin
      failures++; $display("FAIL byte_idle ready=%b done=%b exp 1/0", o_ready, o_done); end
  endtask

  task automatic test_half();
    int busy = 0;
    logic [31:0] wdata_seen = '0;
    mem_word = 32'h1122_3344;
    request(2'b10, 32'h0000_000E, 32'h0000_CAFE);
    tick();
    i_valid = 1'b0;
    for (int i = 0; i < 8 && o_ready === 1'b0; i++) begin
      busy++;
      if (o_mem_we === 1'b1) wdata_seen = o_mem_wdata;
      tick();
    end
    checks++; if (busy != 2) begin failures++; $display("FAIL half_busy got=%0d exp=2", busy); end
    checks++; if (wdata_seen !== 32'hCAFE_3344) begin failures++; $display("FAIL half_wdata got=%h exp=cafe3344", wdata_seen); end
  endtask

  task automatic test_misaligned();
    logic [1:0]  sizes [2] = '{2'b11, 2'b10};
    logic [31:0] addrs [2] = '{32'h0000_0002, 32'h0000_0003};
    for (int i = 0; i < 2; i++) begin
      request(sizes[i], addrs[i], 32'h5555_AAAA);
      tick();
      i_valid = 1'b0;
      checks++; if (o_misaligned !== 1'b1 || o_mem_re !== 1'b0 || o_mem_we !== 1'b0 || o_ready !== 1'b0) begin
        failures++; $display("FAIL misal_err[%0d] mis=%b re=%b we=%b ready=%b exp 1/0/0/0",
                             i, o_misaligned, o_mem_re, o_mem_we, o_ready); end
      tick();
      checks++; if (o_misaligned !== 1'b0 || o_mem_re !== 1'b0 || o_mem_we !== 1'b0 || o_ready !== 1'b1) begin
        failures++; $display("FAIL misal_after[%0d] mis=%b re=%b we=%b ready=%b exp 0/0/0/1",
                             i, o_misaligned, o_mem_re, o_mem_we, o_ready); end
    end
  endtask

  task automatic test_size_none();
    request(2'b00, 32'h0000_0010, 32'h1234_5678);
    tick();
    i_valid = 1'b0;
    checks++; if (o_ready !== 1'b1 || o_mem_re !== 1'b0 || o_mem_we !== 1'b0) begin
      failures++; $display("FAIL none_ignored ready=%b re=%b we=%b exp 1/0/0", o_ready, o_mem_re, o_mem_we); end
  endtask

  task automatic test_reset_abort();
    int bad = 0;
    mem_word = 32'h1122_3344;
    request(2'b01, 32'h0000_0021, 32'h0000_00EE);
    tick();
    i_valid = 1'b0;
    checks++; if (o_mem_re !== 1'b1) begin failures++; $display("FAIL abort_read got=%b exp=1", o_mem_re); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_mem_re !== 1'b0 || o_mem_we !== 1'b0 || o_ready !== 1'b1 || o_mem_addr !== 10'd0) begin
      failures++; $display("FAIL abort_async re=%b we=%b ready=%b addr=%0d exp 0/0/1/0",
                           o_mem_re, o_mem_we, o_ready, o_mem_addr); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_mem_we !== 1'b0 || o_mem_re !== 1'b0 || o_ready !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL abort_release bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_back_to_back();
    mem_word = 32'hAABB_CCDD;
    request(2'b01, 32'h0000_0005, 32'h0000_0077);
    tick();
    request(2'b11, 32'h0000_0020, 32'h1234_5678);
    checks++; if (o_mem_re !== 1'b1 || o_mem_addr !== 10'd1) begin
      failures++; $display("FAIL b2b_read re=%b addr=%0d exp 1/1", o_mem_re, o_mem_addr); end
    tick();
    checks++; if (o_mem_we !== 1'b1 || o_mem_addr !== 10'd1 || o_mem_wdata !== 32'hAABB_77DD) begin
      failures++; $display("FAIL b2b_byte_write we=%b addr=%0d wdata=%h exp 1/1/aabb77dd",
                           o_mem_we, o_mem_addr, o_mem_wdata); end
    tick();
    checks++; if (o_ready !== 1'b1 || o_mem_we !== 1'b0) begin
      failures++; $display("FAIL b2b_ready ready=%b we=%b exp 1/0", o_ready, o_mem_we); end
    tick();
    i_valid = 1'b0;
    checks++; if (o_mem_we !== 1'b1 || o_mem_addr !== 10'd8 || o_mem_wdata !== 32'h1234_5678) begin
      failures++; $display("FAIL b2b_word_write we=%b addr=%0d wdata=%h exp 1/8/12345678",
                           o_mem_we, o_mem_addr, o_mem_wdata); end
    tick();
    checks++; if (o_ready !== 1'b1 || o_mem_we !== 1'b0) begin
      failures++; $display("FAIL b2b_end ready=%b we=%b exp 1/0", o_ready, o_mem_we); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_size_none();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
